// File: rtl/mult_control.sv
// Control FSM for an 8-bit signed shift-add multiplier (X:A:B register chain).
//
// Ports:
//   Clk           rising-edge clock for all state
//   Reset         synchronous active-high reset
//   Run           level request to start one multiply (re-arm needs Run low)
//   ClearA_LoadB  level request, honoured only in IDLE: load B, clear X/A
//   M             current LSB of B, the multiplier bit for this step
//   Clr_XA        clear X and A this cycle
//   Ld_B          load B from switches this cycle
//   Add           load A/X with A+S this cycle
//   Sub           load A/X with A-S this cycle (sign bit of the multiplier)
//   Shift         arithmetic right shift of X:A:B this cycle
//   Busy          multiply in progress (CLR, ARITH, SHIFT)
//   Done          result held, waiting for Run release
//   Step          index of the current multiplier bit, 0..7
module mult_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic       M,
  output logic       Clr_XA,
  output logic       Ld_B,
  output logic       Add,
  output logic       Sub,
  output logic       Shift,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] Step
);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StArith,
    StShift,
    StHold
  } state_e;

  state_e     state;
  logic [2:0] step_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= StIdle;
      step_cnt <= 3'd0;
    end else begin
      unique case (state)
        StIdle: begin
          // Run wins over ClearA_LoadB; loading happens combinationally.
          if (Run) state <= StClr;
        end
        StClr: begin
          step_cnt <= 3'd0;
          state    <= StArith;
        end
        StArith: begin
          state <= StShift;
        end
        StShift: begin
          if (step_cnt == 3'd7) begin
            state <= StHold;
          end else begin
            step_cnt <= step_cnt + 3'd1;
            state    <= StArith;
          end
        end
        StHold: begin
          if (!Run) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  logic load_req;
  logic last_step;

  always_comb begin
    load_req  = (state == StIdle) && ClearA_LoadB && !Run && !Reset;
    last_step = (step_cnt == 3'd7);

    Ld_B   = load_req;
    Clr_XA = load_req || ((state == StClr) && !Reset);
    // The MSB of a two's-complement multiplier has negative weight.
    Add    = (state == StArith) && M && !last_step;
    Sub    = (state == StArith) && M && last_step;

    Shift  = (state == StShift);
    Busy   = (state == StClr) || (state == StArith) || (state == StShift);
    Done   = (state == StHold);
    Step   = step_cnt;
  end

endmodule

// File: tb/tb_mult_control.sv
module tb_mult_control;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic       M;
  logic       Clr_XA;
  logic       Ld_B;
  logic       Add;
  logic       Sub;
  logic       Shift;
  logic       Busy;
  logic       Done;
  logic [2:0] Step;

  mult_control dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_XA       (Clr_XA),
    .Ld_B         (Ld_B),
    .Add          (Add),
    .Sub          (Sub),
    .Shift        (Shift),
    .Busy         (Busy),
    .Done         (Done),
    .Step         (Step)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: t counts cycles since leaving IDLE.
  //   t=0 IDLE, t=1 CLR, even t in 2..16 ARITH, odd t in 3..17 SHIFT, t=18 HOLD.
  int m_t;
  int m_step;

  // Pulse counters over a window, sampled from the DUT.
  int add_cnt, sub_cnt, shift_cnt, clr_cnt, ldb_cnt, both_cnt;
  logic obs_done;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_arith();
    return (m_t >= 2) && (m_t <= 16) && (m_t % 2 == 0);
  endfunction

  // Called with inputs already driven, just after a falling edge.
  task automatic cyc();
    bit idle, load, arith;
    #1;
    idle  = (m_t == 0);
    load  = idle && ClearA_LoadB && !Run && !Reset;
    arith = m_arith();
    check("Ld_B",   int'(Ld_B),   int'(load));
    check("Clr_XA", int'(Clr_XA), int'(load || (m_t == 1 && !Reset)));
    check("Add",    int'(Add),    int'(arith && M && m_step != 7));
    check("Sub",    int'(Sub),    int'(arith && M && m_step == 7));
    check("Shift",  int'(Shift),  int'((m_t >= 3) && (m_t <= 17) && (m_t % 2 == 1)));
    check("Busy",   int'(Busy),   int'((m_t >= 1) && (m_t <= 17)));
    check("Done",   int'(Done),   int'(m_t == 18));
    check("Step",   int'(Step),   m_step);
    add_cnt   += int'(Add);
    sub_cnt   += int'(Sub);
    shift_cnt += int'(Shift);
    clr_cnt   += int'(Clr_XA);
    ldb_cnt   += int'(Ld_B);
    both_cnt  += int'(Add && Sub);
    obs_done   = Done;
    @(posedge Clk);
    if (Reset) begin
      m_t    = 0;
      m_step = 0;
    end else if (m_t == 0) begin
      if (Run) m_t = 1;
    end else if (m_t <= 17) begin
      m_t++;
      if (m_t <= 17) m_step = (m_t - 2) / 2;
    end else if (!Run) begin
      m_t = 0;
    end
    @(negedge Clk);
  endtask

  task automatic clr_counts();
    add_cnt = 0; sub_cnt = 0; shift_cnt = 0; clr_cnt = 0; ldb_cnt = 0; both_cnt = 0;
  endtask

  // Holds Run for 17 + hold_cycles cycles feeding M from b; then drops Run.
  task automatic run_mult(input logic [7:0] b, input int hold_cycles, output int first_done);
    first_done = -1;
    Run = 1'b1;
    for (int i = 0; i < 17 + hold_cycles; i++) begin
      M = m_arith() ? b[m_step] : 1'($urandom);
      ClearA_LoadB = 1'($urandom);
      cyc();
      if (obs_done && first_done < 0) first_done = i;
    end
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    cyc();
  endtask

  int fd;

  initial begin
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b1; M = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    m_t = 0; m_step = 0;
    // Reset held with load request: Ld_B/Clr_XA must stay low.
    Run = 1'b1;
    cyc();
    Run = 1'b0;
    cyc();
    Reset = 1'b0; ClearA_LoadB = 1'b0;
    cyc();

    // Load request in IDLE for two cycles.
    clr_counts();
    ClearA_LoadB = 1'b1;
    cyc();
    cyc();
    ClearA_LoadB = 1'b0;
    check("load_ldb_cnt", ldb_cnt, 2);
    check("load_clr_cnt", clr_cnt, 2);
    check("load_arith_cnt", add_cnt + sub_cnt + shift_cnt, 0);

    // B=0x05, Run held 40 cycles in total, load requests ignored.
    clr_counts();
    run_mult(8'h05, 23, fd);
    check("b05_add_cnt", add_cnt, 2);
    check("b05_sub_cnt", sub_cnt, 0);
    check("b05_shift_cnt", shift_cnt, 8);
    check("b05_clr_cnt", clr_cnt, 1);
    check("b05_ldb_cnt", ldb_cnt, 0);
    check("b05_done_cycle", fd, 18);
    check("b05_idle_after", int'(Busy || Done), 0);

    // B=0xFF: seven adds then one subtract, never together.
    clr_counts();
    run_mult(8'hFF, 2, fd);
    check("bff_add_cnt", add_cnt, 7);
    check("bff_sub_cnt", sub_cnt, 1);
    check("bff_both_cnt", both_cnt, 0);
    check("bff_done_cycle", fd, 18);

    // Reset during SHIFT with Step=4 (t=11).
    Run = 1'b1;
    for (int i = 0; i < 40 && m_t != 11; i++) begin
      M = 1'($urandom);
      cyc();
    end
    check("mid_reached", m_t, 11);
    check("mid_step", int'(Step), 4);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0; Run = 1'b0;
    clr_counts();
    cyc();
    check("mid_step_after", int'(Step), 0);
    check("mid_busy_after", int'(Busy), 0);
    check("mid_done_after", int'(Done), 0);
    cyc();
    check("mid_shift_after", shift_cnt, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      Run          = ($urandom_range(0, 3) != 0) ? Run : ~Run;
      ClearA_LoadB = 1'($urandom);
      M            = 1'($urandom);
      Reset        = ($urandom_range(0, 60) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
